// File: rtl/pwm_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_decoder
//  Purpose  : Measures the period and duty cycle of an asynchronous PWM input.
//             A 2-flop synchronizer feeds an IDLE/HIGH/LOW measurement FSM.
//             Each complete period is divided in an 11-step restoring divider
//             to give duty in units of 1/1024. A timeout flags a stuck input.
//  Options  : PWM_DEC_GLITCH_FILTER_EN - the synchronized level only changes
//             after 3 equal samples, so pulses shorter than 3 cycles are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_decoder #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd8000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pwm_in,
   output logic [9:0]  duty,
   output logic [31:0] period,
   output logic        valid,
   output logic        stuck
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [3:0]  c_DIV_LAST = 4'd10;    // index of the 11th iteration
   localparam logic [10:0] c_DUTY_MAX = 11'd1023;

   logic        r_sync1;
   logic        r_sync2;
   logic        r_level_q;
   logic        w_level;
   logic        w_rise;
   logic        w_fall;

   state_t      r_state;
   logic [31:0] r_per_cnt;
   logic [31:0] r_high_cnt;
   logic [31:0] r_to_cnt;
   logic        w_timeout;

   logic        r_busy;
   logic [3:0]  r_div_cnt;
   logic [41:0] r_dvd;
   logic [31:0] r_rem;
   logic [9:0]  r_quot;
   logic [31:0] r_div_per;
   logic [41:0] w_dividend;
   logic [32:0] w_rem_sh;
   logic [31:0] w_rem_diff;
   logic        w_ge;
   logic [10:0] w_quot_nx;
   logic [9:0]  w_duty_sat;

   // Two-flop synchronizer plus the registered copy used for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level_q <= 1'b0;
      end else begin
         r_sync1   <= pwm_in;
         r_sync2   <= r_sync1;
         r_level_q <= w_level;
      end
   end

`ifdef PWM_DEC_GLITCH_FILTER_EN
   logic [1:0] r_hist;

   // Keep the two previous synchronized samples for the 3-sample agreement test
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_hist <= 2'b00;
      else     r_hist <= {r_hist[0], r_sync2};
   end

   // Level follows the input only once three consecutive samples agree
   always_comb begin
      w_level = r_level_q;
      if ((r_sync2 == r_hist[0]) && (r_sync2 == r_hist[1])) w_level = r_sync2;
   end
`else
   // Unfiltered: every synchronized change is an edge
   always_comb begin
      w_level = r_sync2;
   end
`endif

   // Edge detection, divider datapath and timeout event
   always_comb begin
      w_rise     = w_level & ~r_level_q;
      w_fall     = ~w_level & r_level_q;
      w_timeout  = ~w_rise && (r_to_cnt == (TIMEOUT_CYCLES - 32'd1));
      w_dividend = {r_high_cnt, 10'd0};
      w_rem_sh   = {r_rem, r_dvd[10]};
      w_ge       = (w_rem_sh >= {1'b0, r_div_per});
      // Only used when w_ge, where the true difference is below the divisor
      w_rem_diff = w_rem_sh[31:0] - r_div_per;
      w_quot_nx  = {r_quot, w_ge};
      w_duty_sat = (w_quot_nx > c_DUTY_MAX) ? 10'd1023 : w_quot_nx[9:0];
   end

   // Measurement FSM, counters, divider and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_per_cnt  <= 32'd0;
         r_high_cnt <= 32'd0;
         r_to_cnt   <= 32'd0;
         r_busy     <= 1'b0;
         r_div_cnt  <= 4'd0;
         r_dvd      <= 42'd0;
         r_rem      <= 32'd0;
         r_quot     <= 10'd0;
         r_div_per  <= 32'd0;
         duty       <= 10'd0;
         period     <= 32'd0;
         valid      <= 1'b0;
         stuck      <= 1'b0;
      end else begin
         valid <= 1'b0;

         if (w_rise)                          r_to_cnt <= 32'd0;
         else if (r_to_cnt != TIMEOUT_CYCLES) r_to_cnt <= r_to_cnt + 32'd1;

         if (r_busy) begin
            r_rem     <= w_ge ? w_rem_diff : w_rem_sh[31:0];
            r_dvd     <= r_dvd << 1;
            r_quot    <= w_quot_nx[9:0];
            r_div_cnt <= r_div_cnt + 4'd1;
            if (r_div_cnt == c_DIV_LAST) begin
               r_busy <= 1'b0;
               duty   <= w_duty_sat;
               period <= r_div_per;
               valid  <= 1'b1;
               stuck  <= 1'b0;
            end
         end

         case (r_state)
            IDLE: begin
               // First edge only opens a measurement window
               if (w_rise) begin
                  r_per_cnt  <= 32'd0;
                  r_high_cnt <= 32'd0;
                  r_state    <= HIGH;
               end
            end
            HIGH: begin
               r_per_cnt  <= r_per_cnt + 32'd1;
               r_high_cnt <= r_high_cnt + 32'd1;
               if (w_fall) r_state <= LOW;
            end
            LOW: begin
               if (w_rise) begin
                  // A result still in the divider keeps priority; this one is dropped
                  if (!r_busy) begin
                     r_busy    <= 1'b1;
                     r_div_cnt <= 4'd0;
                     r_div_per <= r_per_cnt + 32'd1;
                     r_dvd     <= w_dividend;
                     r_rem     <= {1'b0, w_dividend[41:11]};
                     r_quot    <= 10'd0;
                  end
                  r_per_cnt  <= 32'd0;
                  r_high_cnt <= 32'd0;
                  r_state    <= HIGH;
               end else begin
                  r_per_cnt <= r_per_cnt + 32'd1;
               end
            end
            default: r_state <= IDLE;
         endcase

         // Timeout overrides any divider completion in the same cycle
         if (w_timeout) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            stuck   <= 1'b1;
            valid   <= ~stuck;
            if (!stuck) begin
               period <= 32'd0;
               duty   <= w_level ? 10'd1023 : 10'd0;
            end else begin
               period <= period;
               duty   <= duty;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pwm_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_decoder
//  Purpose  : Self-checking bench for pwm_decoder: table of steady PWM shapes
//             plus directed sequences for busy-divider discard, glitches,
//             timeout/recovery and reset with exact output latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_decoder;

`ifdef PWM_DEC_GLITCH_FILTER_EN
   localparam int c_F = 2;
`else
   localparam int c_F = 0;
`endif

   typedef struct {
      int per;
      int high;
      int reps;
      int exp_duty;
      int exp_per;
      int exp_cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        pwm_in;
   logic [9:0]  duty;
   logic [31:0] period;
   logic        valid;
   logic        stuck;

   int n_vec = 0;
   int n_fail = 0;
   int v_idx = 0;
   int base;

   logic [9:0]  h_duty  [0:127];
   logic [31:0] h_per   [0:127];
   logic        h_stuck [0:127];

   vec_t vecs [0:7];

   always #5 clk = ~clk;

   pwm_decoder dut (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm_in),
      .duty   (duty),
      .period (period),
      .valid  (valid),
      .stuck  (stuck)
   );

   // Record every valid pulse with the outputs it carried
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         h_duty[v_idx % 128]  = duty;
         h_per[v_idx % 128]   = period;
         h_stuck[v_idx % 128] = stuck;
         v_idx = v_idx + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic drive_cycles(input int n, input logic lvl);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 pwm_in = lvl;
      end
   endtask

   task automatic run_period(input int per, input int high);
      for (int i = 0; i < per; i++) begin
         @(posedge clk);
         #1 pwm_in = (i < high);
      end
   endtask

   initial begin
      vecs[0] = '{4000,  781, 3,  199, 4000, 2};
      vecs[1] = '{4000, 2000, 2,  512, 4000, 2};
`ifdef PWM_DEC_GLITCH_FILTER_EN
      vecs[2] = '{4000, 3997, 2, 1023, 4000, 2};
      vecs[4] = '{1000,    3, 2,    3, 1000, 2};
`else
      vecs[2] = '{4000, 3999, 2, 1023, 4000, 2};
      vecs[4] = '{1000,    1, 2,    1, 1000, 2};
`endif
      vecs[3] = '{ 100,   25, 3,  256,  100, 3};
      vecs[5] = '{ 300,  200, 2,  682,  300, 2};
      vecs[6] = '{  17,    9, 3,  542,   17, 3};
      vecs[7] = '{  12,    6, 3,  512,   12, 3};

      rst    = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_duty",   32'(duty),   32'd0);
      chk("rst_period", period,      32'd0);
      chk("rst_valid",  32'(valid),  32'd0);
      chk("rst_stuck",  32'(stuck),  32'd0);
      rst = 1'b0;

      // Steady waveforms from the table
      for (int v = 0; v < 8; v++) begin
         base = v_idx;
         for (int r = 0; r < vecs[v].reps; r++) run_period(vecs[v].per, vecs[v].high);
         drive_cycles(20, 1'b0);
         chk($sformatf("v%0d_duty", v),   32'(h_duty[(v_idx + 127) % 128]), 32'(vecs[v].exp_duty));
         chk($sformatf("v%0d_period", v), h_per[(v_idx + 127) % 128],     32'(vecs[v].exp_per));
         chk($sformatf("v%0d_stuck", v),  32'(stuck),                     32'd0);
         chk($sformatf("v%0d_count", v),  32'(v_idx - base),              32'(vecs[v].exp_cnt));
      end

      // Short periods right after a long one: rises during division are dropped
      run_period(4000, 781);
      base = v_idx;
      repeat (5) run_period(8, 4);
      drive_cycles(30, 1'b0);
      chk("busy_count",   32'(v_idx - base),           32'd3);
      chk("busy_duty0",   32'(h_duty[base % 128]),     32'd199);
      chk("busy_period0", h_per[base % 128],           32'd4000);
      chk("busy_duty1",   32'(h_duty[(base + 1) % 128]), 32'd512);
      chk("busy_period1", h_per[(base + 1) % 128],     32'd8);

      // Two-cycle low glitch inside a 2000-cycle high
      base = v_idx;
      drive_cycles(1000, 1'b1);
      drive_cycles(2, 1'b0);
      drive_cycles(998, 1'b1);
      drive_cycles(2000, 1'b0);
      run_period(4000, 2000);
`ifdef PWM_DEC_GLITCH_FILTER_EN
      chk("glitch_count",   32'(v_idx - base),             32'd2);
      chk("glitch_duty1",   32'(h_duty[(base + 1) % 128]), 32'd512);
      chk("glitch_period1", h_per[(base + 1) % 128],       32'd4000);
`else
      chk("glitch_count",   32'(v_idx - base),             32'd3);
      chk("glitch_duty1",   32'(h_duty[(base + 1) % 128]), 32'd1021);
      chk("glitch_period1", h_per[(base + 1) % 128],       32'd1002);
      chk("glitch_duty2",   32'(h_duty[(base + 2) % 128]), 32'd340);
      chk("glitch_period2", h_per[(base + 2) % 128],       32'd2998);
`endif

      // Input held high for 10000 cycles after a rising edge
      base = v_idx;
      @(posedge clk);
      #1 pwm_in = 1'b1;
      repeat (8001) @(posedge clk);
      #1 chk("to_stuck_early", 32'(stuck), 32'd0);
      repeat (3 + c_F) @(posedge clk);
      #1 chk("to_stuck_set", 32'(stuck), 32'd1);
      drive_cycles(10000 - 8005 - c_F, 1'b1);
      chk("to_count",       32'(v_idx - base),             32'd2);
      chk("to_valid_duty",  32'(h_duty[(base + 1) % 128]), 32'd1023);
      chk("to_valid_per",   h_per[(base + 1) % 128],       32'd0);
      chk("to_valid_stuck", 32'(h_stuck[(base + 1) % 128]), 32'd1);
      chk("to_duty",        32'(duty),                     32'd1023);
      chk("to_period",      period,                        32'd0);

      // Recovery: stuck holds until a full measurement completes
      drive_cycles(2000, 1'b0);
      base = v_idx;
      run_period(4000, 2000);
      chk("rec_stuck_hold", 32'(stuck),                32'd1);
      chk("rec_count0",     32'(v_idx - base),         32'd0);
      run_period(4000, 2000);
      chk("rec_count1",     32'(v_idx - base),         32'd1);
      chk("rec_duty",       32'(h_duty[base % 128]),   32'd512);
      chk("rec_period",     h_per[base % 128],         32'd4000);
      chk("rec_valid_stuck", 32'(h_stuck[base % 128]), 32'd0);
      chk("rec_stuck",      32'(stuck),                32'd0);

      // Reset 1000 cycles into a period, then exact latency of the first result
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1 pwm_in = (i < 781);
      end
      #2 rst = 1'b1;
      #1;
      chk("arst_duty",   32'(duty),  32'd0);
      chk("arst_period", period,     32'd0);
      chk("arst_valid",  32'(valid), 32'd0);
      chk("arst_stuck",  32'(stuck), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      drive_cycles(2000, 1'b0);
      base = v_idx;
      run_period(4000, 781);
      chk("post_rst_count0", 32'(v_idx - base), 32'd0);
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1 pwm_in = (i < 781);
         if (i == 13 + c_F) chk("lat_before", 32'(valid), 32'd0);
         if (i == 14 + c_F) begin
            chk("lat_valid",  32'(valid), 32'd1);
            chk("lat_duty",   32'(duty),  32'd199);
            chk("lat_period", period,     32'd4000);
         end
         if (i == 15 + c_F) chk("lat_after", 32'(valid), 32'd0);
      end
      chk("post_rst_count1", 32'(v_idx - base), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
